// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: register address
// width, the $zero register index, mult/div latency default and the
// mult/div busy FSM state type.
package pipe_pkg;

  localparam int REG_AW     = 5;
  localparam int ZERO_REG   = 0;
  localparam int MD_LATENCY = 32;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl. The master modport is the pipeline
// (it supplies stage information and consumes enables). The slave modport
// is the hazard controller.
// Optional build macro: HAZARD_PERF_EN adds the stall/flush perf counters.
interface hazard_ctrl_if #(
  parameter int REG_AW = pipe_pkg::REG_AW
);

  logic              idex_memread;
  logic              idex_regwrite;
  logic [REG_AW-1:0] idex_rd;
  logic              exmem_memread;
  logic [REG_AW-1:0] exmem_rd;
  logic [REG_AW-1:0] ifid_rs;
  logic [REG_AW-1:0] ifid_rt;
  logic              ifid_uses_rt;
  logic              ifid_is_branch;
  logic              ifid_reads_hilo;
  logic              md_start;
  logic              branch_taken;

  logic              pc_write;
  logic              ifid_write;
  logic              idex_bubble;
  logic              ifid_flush;
  logic              md_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0]       stall_cycles;
  logic [15:0]       flush_count;
`endif

  modport master (
    output idex_memread, idex_regwrite, idex_rd, exmem_memread, exmem_rd,
           ifid_rs, ifid_rt, ifid_uses_rt, ifid_is_branch, ifid_reads_hilo,
           md_start, branch_taken,
`ifdef HAZARD_PERF_EN
    input  stall_cycles, flush_count,
`endif
    input  pc_write, ifid_write, idex_bubble, ifid_flush, md_busy
  );

  modport slave (
    input  idex_memread, idex_regwrite, idex_rd, exmem_memread, exmem_rd,
           ifid_rs, ifid_rt, ifid_uses_rt, ifid_is_branch, ifid_reads_hilo,
           md_start, branch_taken,
`ifdef HAZARD_PERF_EN
    output stall_cycles, flush_count,
`endif
    output pc_write, ifid_write, idex_bubble, ifid_flush, md_busy
  );

endinterface

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// Mult/div busy tracker. Loads MD_LATENCY-1 when a mult/div enters EX and
// counts down to zero; md_busy is registered and high while the count is
// nonzero. A new md_start always restarts the count (no queueing).
//
// state   | meaning
// RUN     | md_cnt == 0, HI/LO valid
// MD_WAIT | md_cnt != 0, HI/LO result still in flight
module md_busy_ctr #(
  parameter int MD_LATENCY = pipe_pkg::MD_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start,
  output logic md_busy
);
  import pipe_pkg::*;

  localparam int                CNT_W  = $clog2(MD_LATENCY + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  md_state_t        state;
  logic [CNT_W-1:0] md_cnt;

  // Busy FSM: reload on md_start, else count down in MD_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      md_cnt  <= '0;
      md_busy <= 1'b0;
    end else if (md_start) begin
      state   <= MD_WAIT;
      md_cnt  <= RELOAD;
      md_busy <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          md_cnt  <= '0;
          md_busy <= 1'b0;
        end
        MD_WAIT: begin
          md_cnt <= md_cnt - ONE;
          if (md_cnt == ONE) begin
            state   <= RUN;
            md_busy <= 1'b0;
          end else begin
            md_busy <= 1'b1;
          end
        end
        default: begin
          state   <= RUN;
          md_cnt  <= '0;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller beside the ID stage: load-use, branch-in-ID
// operand hazards (EX and MEM), HI/LO interlock against the mult/div unit,
// and taken-branch flush. Stall is combinational; a stall suppresses the
// flush so the branch is only squashed once its operands are ready.
// Optional build macro: HAZARD_PERF_EN adds saturating stall/flush counters.
module hazard_ctrl #(
  parameter int REG_AW     = pipe_pkg::REG_AW,
  parameter int MD_LATENCY = pipe_pkg::MD_LATENCY
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hif
);
  import pipe_pkg::*;

  // $zero never creates a dependency.
  function automatic logic reg_match(input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] b);
    return (a == b) && (a != REG_AW'(ZERO_REG));
  endfunction

  logic ex_dep;
  logic mem_dep;
  logic load_use;
  logic br_ex;
  logic br_mem;
  logic hilo;
  logic stall;
  logic md_busy;

  md_busy_ctr #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_busy_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_start (hif.md_start),
    .md_busy  (md_busy)
  );

  // Source-operand matches against EX and MEM destinations.
  always_comb begin
    ex_dep   = reg_match(hif.idex_rd, hif.ifid_rs) |
               (hif.ifid_uses_rt & reg_match(hif.idex_rd, hif.ifid_rt));
    mem_dep  = reg_match(hif.exmem_rd, hif.ifid_rs) |
               (hif.ifid_uses_rt & reg_match(hif.exmem_rd, hif.ifid_rt));
    load_use = hif.idex_memread & ex_dep;
    br_ex    = hif.ifid_is_branch & hif.idex_regwrite & ex_dep;
    br_mem   = hif.ifid_is_branch & hif.exmem_memread & mem_dep;
    hilo     = hif.ifid_reads_hilo & md_busy;
    stall    = load_use | br_ex | br_mem | hilo;
  end

  assign hif.pc_write    = ~stall;
  assign hif.ifid_write  = ~stall;
  assign hif.idex_bubble = stall;
  assign hif.ifid_flush  = hif.branch_taken & ~stall;
  assign hif.md_busy     = md_busy;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  // Saturating counts of stalled cycles and flushed cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (hif.ifid_flush && (flush_count != '1))
        flush_count <= flush_count + 16'd1;
    end
  end

  assign hif.stall_cycles = stall_cycles;
  assign hif.flush_count  = flush_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl, built with MD_LATENCY=4.
// Output vector order: {pc_write, ifid_write, idex_bubble, ifid_flush, md_busy}.
module tb_hazard_ctrl;

  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00100;
  localparam logic [4:0] O_FLUSH = 5'b11010;
  localparam logic [4:0] O_HILO  = 5'b00101;
  localparam logic [4:0] O_BUSY  = 5'b11001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  hazard_ctrl_if #(.REG_AW(5)) hif();

  hazard_ctrl #(
    .REG_AW     (5),
    .MD_LATENCY (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {hif.pc_write, hif.ifid_write, hif.idex_bubble, hif.ifid_flush, hif.md_busy};
  endfunction

  task automatic clear_inputs();
    hif.idex_memread    = 1'b0;
    hif.idex_regwrite   = 1'b0;
    hif.idex_rd         = '0;
    hif.exmem_memread   = 1'b0;
    hif.exmem_rd        = '0;
    hif.ifid_rs         = '0;
    hif.ifid_rt         = '0;
    hif.ifid_uses_rt    = 1'b0;
    hif.ifid_is_branch  = 1'b0;
    hif.ifid_reads_hilo = 1'b0;
    hif.md_start        = 1'b0;
    hif.branch_taken    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    hif.ifid_reads_hilo = 1'b1;
    #1;
    n_cmp++;
    if (outs() !== O_RUN) begin
      $display("FAIL reset got=%b exp=%b", outs(), O_RUN); n_err++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_load_use();
    step();
    hif.idex_memread = 1'b1; hif.idex_regwrite = 1'b1; hif.idex_rd = 5'd8; hif.ifid_rs = 5'd8;
    #1;
    n_cmp++;
    if (outs() !== O_STALL) begin
      $display("FAIL load_use_stall got=%b exp=%b", outs(), O_STALL); n_err++;
    end
    step();
    clear_inputs(); hif.ifid_rs = 5'd8;
    #1;
    n_cmp++;
    if (outs() !== O_RUN) begin
      $display("FAIL load_use_release got=%b exp=%b", outs(), O_RUN); n_err++;
    end
    step();
    hif.idex_memread = 1'b1; hif.idex_rd = 5'd0; hif.ifid_rs = 5'd0;
    #1;
    n_cmp++;
    if (outs() !== O_RUN) begin
      $display("FAIL load_use_zero got=%b exp=%b", outs(), O_RUN); n_err++;
    end
    hif.idex_rd = 5'd8; hif.ifid_rs = 5'd9;
    #1;
    n_cmp++;
    if (outs() !== O_RUN) begin
      $display("FAIL load_use_nomatch got=%b exp=%b", outs(), O_RUN); n_err++;
    end
    clear_inputs();
  endtask

  task automatic test_rt_qualifier();
    step();
    hif.idex_memread = 1'b1; hif.idex_rd = 5'd9; hif.ifid_rs = 5'd3; hif.ifid_rt = 5'd9;
    hif.ifid_uses_rt = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== O_RUN) begin
      $display("FAIL rt_unused got=%b exp=%b", outs(), O_RUN); n_err++;
    end
    hif.ifid_uses_rt = 1'b1;
    #1;
    n_cmp++;
    if (outs() !== O_STALL) begin
      $display("FAIL rt_used got=%b exp=%b", outs(), O_STALL); n_err++;
    end
    hif.idex_rd = 5'd0; hif.ifid_rt = 5'd0;
    #1;
    n_cmp++;
    if (outs() !== O_RUN) begin
      $display("FAIL rt_zero got=%b exp=%b", outs(), O_RUN); n_err++;
    end
    clear_inputs();
  endtask

  task automatic test_branch_after_load();
    step();
    // lw $5 in EX, beq $5,$6 in ID, resolved taken (must wait for operands)
    hif.idex_memread = 1'b1; hif.idex_regwrite = 1'b1; hif.idex_rd = 5'd5;
    hif.ifid_is_branch = 1'b1; hif.ifid_rs = 5'd5; hif.ifid_rt = 5'd6; hif.ifid_uses_rt = 1'b1;
    hif.branch_taken = 1'b1;
    #1;
    n_cmp++;
    if (outs() !== O_STALL) begin
      $display("FAIL br_load_ex got=%b exp=%b", outs(), O_STALL); n_err++;
    end
    step();
    hif.idex_memread = 1'b0; hif.idex_regwrite = 1'b0; hif.idex_rd = 5'd0;
    hif.exmem_memread = 1'b1; hif.exmem_rd = 5'd5;
    #1;
    n_cmp++;
    if (outs() !== O_STALL) begin
      $display("FAIL br_load_mem got=%b exp=%b", outs(), O_STALL); n_err++;
    end
    step();
    hif.exmem_memread = 1'b0; hif.exmem_rd = 5'd0;
    #1;
    n_cmp++;
    if (outs() !== O_FLUSH) begin
      $display("FAIL br_load_flush got=%b exp=%b", outs(), O_FLUSH); n_err++;
    end
    step();
    clear_inputs();
    #1;
    n_cmp++;
    if (outs() !== O_RUN) begin
      $display("FAIL br_load_after got=%b exp=%b", outs(), O_RUN); n_err++;
    end
  endtask

  task automatic test_branch_after_alu();
    step();
    // ALU result in EX feeding a non-branch: forwarding covers it, no stall
    hif.idex_regwrite = 1'b1; hif.idex_rd = 5'd7; hif.ifid_rs = 5'd7;
    #1;
    n_cmp++;
    if (outs() !== O_RUN) begin
      $display("FAIL alu_nonbranch got=%b exp=%b", outs(), O_RUN); n_err++;
    end
    hif.ifid_is_branch = 1'b1; hif.branch_taken = 1'b1;
    #1;
    n_cmp++;
    if (outs() !== O_STALL) begin
      $display("FAIL br_alu_ex got=%b exp=%b", outs(), O_STALL); n_err++;
    end
    step();
    hif.idex_regwrite = 1'b0; hif.idex_rd = 5'd0; hif.exmem_rd = 5'd7;
    #1;
    n_cmp++;
    if (outs() !== O_FLUSH) begin
      $display("FAIL br_alu_flush got=%b exp=%b", outs(), O_FLUSH); n_err++;
    end
    clear_inputs();
  endtask

  task automatic test_md_interlock();
    logic [4:0] exp;
    step();
    hif.md_start = 1'b1;
    #1;
    n_cmp++;
    if (outs() !== O_RUN) begin
      $display("FAIL md_cycle0 got=%b exp=%b", outs(), O_RUN); n_err++;
    end
    for (int c = 1; c <= 5; c++) begin
      step();
      hif.md_start = 1'b0; hif.ifid_reads_hilo = 1'b1;
      #1;
      exp = (c <= 3) ? O_HILO : O_RUN;
      n_cmp++;
      if (outs() !== exp) begin
        $display("FAIL md_interlock_c%0d got=%b exp=%b", c, outs(), exp); n_err++;
      end
    end
    clear_inputs();
  endtask

  task automatic test_md_restart();
    // starts at cycles 0 and 2: busy 1..5
    logic [7:0] busy_a = 8'b0011_1110;
    // starts at cycles 0 and 3 (reload on the last busy cycle): busy 1..6
    logic [7:0] busy_b = 8'b0111_1110;
    for (int c = 0; c <= 7; c++) begin
      step();
      hif.md_start = (c == 0) || (c == 2);
      #1;
      n_cmp++;
      if (hif.md_busy !== busy_a[c]) begin
        $display("FAIL md_restart_c%0d got=%b exp=%b", c, hif.md_busy, busy_a[c]); n_err++;
      end
    end
    for (int c = 0; c <= 7; c++) begin
      step();
      hif.md_start = (c == 0) || (c == 3);
      #1;
      n_cmp++;
      if (hif.md_busy !== busy_b[c]) begin
        $display("FAIL md_reload_c%0d got=%b exp=%b", c, hif.md_busy, busy_b[c]); n_err++;
      end
    end
    clear_inputs();
  endtask

  task automatic test_md_with_stall();
    step();
    hif.idex_memread = 1'b1; hif.idex_rd = 5'd4; hif.ifid_rs = 5'd4; hif.md_start = 1'b1;
    #1;
    n_cmp++;
    if (outs() !== O_STALL) begin
      $display("FAIL md_stall_same got=%b exp=%b", outs(), O_STALL); n_err++;
    end
    step();
    clear_inputs();
    #1;
    n_cmp++;
    if (outs() !== O_BUSY) begin
      $display("FAIL md_stall_next got=%b exp=%b", outs(), O_BUSY); n_err++;
    end
    repeat (3) step();
  endtask

  task automatic test_async_reset();
    step();
    hif.md_start = 1'b1;
    step();
    hif.md_start = 1'b0;
    step();
    hif.ifid_reads_hilo = 1'b1;
    #1;
    n_cmp++;
    if (outs() !== O_HILO) begin
      $display("FAIL areset_before got=%b exp=%b", outs(), O_HILO); n_err++;
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== O_RUN) begin
      $display("FAIL areset_async got=%b exp=%b", outs(), O_RUN); n_err++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      #1;
      n_cmp++;
      if (outs() !== O_RUN) begin
        $display("FAIL areset_after_%0d got=%b exp=%b", c, outs(), O_RUN); n_err++;
      end
    end
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #12;
    test_reset();
    test_load_use();
    test_rt_qualifier();
    test_branch_after_load();
    test_branch_after_alu();
    test_md_interlock();
    test_md_restart();
    test_md_with_stall();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage MIPS core, next generation of the load-use detector. Sits beside the ID stage and drives PC/IF-ID write enables, the ID/EX bubble mux and the IF/ID flush. Adds destination-based matching with $zero exclusion, branch-in-ID operand hazards, HI/LO interlock against a multi-cycle mult/div unit (sequential busy counter), and taken-branch flush.

Parameters:
REG_AW, 5, register address width
MD_LATENCY, 32, cycles from md_start until HI/LO valid (>=2)
CNT_W, $clog2(MD_LATENCY+1), busy counter width (derived, not overridden)

Ports:
clk  in  1  core clock
rst_n  in  1  reset, active-low, asynchronous
idex_memread  in  1  instruction in EX is a load
idex_regwrite  in  1  instruction in EX writes a GPR
idex_rd  in  REG_AW  destination register of EX instruction
exmem_memread  in  1  instruction in MEM is a load
exmem_rd  in  REG_AW  destination register of MEM instruction
ifid_rs  in  REG_AW  rs of ID instruction
ifid_rt  in  REG_AW  rt of ID instruction
ifid_uses_rt  in  1  ID instruction reads rt as a source
ifid_is_branch  in  1  ID instruction is beq/bne (compared in ID)
ifid_reads_hilo  in  1  ID instruction is mfhi/mflo/mult/div
md_start  in  1  mult/div enters EX this cycle
branch_taken  in  1  ID branch resolved taken
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register enable
idex_bubble  out  1  select zero control word into ID/EX
ifid_flush  out  1  clear IF/ID to NOP
md_busy  out  1  mult/div counter nonzero

Behaviour:
- Clock: single clk; reset asynchronous active-low (rst_n). Reset: state RUN, md_cnt=0; md_busy=0, stall=0, so pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
- Match(a,b) true only when a==b and a!=0; rt compared only if ifid_uses_rt.
- load_use = idex_memread & Match(idex_rd, rs|rt).
- br_ex = ifid_is_branch & idex_regwrite & Match(idex_rd, rs|rt) (covers load in EX).
- br_mem = ifid_is_branch & exmem_memread & Match(exmem_rd, rs|rt).
- hilo = ifid_reads_hilo & md_busy.
- stall = load_use|br_ex|br_mem|hilo; combinational, same cycle. stall -> pc_write=0, ifid_write=0, idex_bubble=1.
- Branch after load: 2 stall cycles (EX then MEM); after ALU op: 1.
- ifid_flush = branch_taken & ~stall. Stall wins; flush happens after stall clears.
- FSM: RUN (md_cnt==0) and MD_WAIT (md_cnt!=0). md_start in any state -> md_cnt=MD_LATENCY-1, MD_WAIT (restart, no queueing). MD_WAIT: decrement each cycle; 1->0 returns to RUN. md_start on the 1->0 cycle reloads.
- md_busy = (md_cnt!=0), registered. mfhi in ID stalls while busy, issues cycle busy drops.
- md_start coincident with stall is still honoured (EX advances).
- rst_n low mid-count: counter cleared immediately, outputs to reset values, no stall.

Optional Feature:
HAZARD_PERF_EN: adds outputs stall_cycles[31:0] and flush_count[15:0]; free-running saturating counters of cycles with stall=1 and with ifid_flush=1, cleared by rst_n. Undefined: ports and logic absent, behaviour otherwise identical.

Decomposition:
- Shared package pipe_pkg: REG_AW, ZERO_REG=0, fsm state enum {RUN, MD_WAIT}, MD_LATENCY default.
- Sub-module md_busy_ctr (load/decrement counter, md_busy output); comparator and stall logic stay in hazard_ctrl.

Test Plan:
- Load-use: idex_memread=1, idex_rd=8, ifid_rs=8 -> 1 cycle pc_write=0, idex_bubble=1; idex_rd=0, ifid_rs=0 -> no stall.
- rt qualifier: idex_memread=1, idex_rd=9, ifid_rt=9, ifid_uses_rt=0 -> no stall; ifid_uses_rt=1 -> stall.
- Branch after lw $5: beq $5,$6 in ID -> stall 2 cycles (EX match, then exmem_rd=5), then branch_taken=1 -> ifid_flush=1 exactly 1 cycle.
- Mult/div with MD_LATENCY=4: md_start at cycle 0, mfhi in ID from cycle 1 -> md_busy 1 on cycles 1-3, stall on cycles 1-3, issue at cycle 4.
- Restart: md_start at cycles 0 and 2 -> md_busy stays 1 through cycle 5, clears cycle 6.
- rst_n pulsed low at cycle 2 of a count -> md_busy=0 and pc_write=1 asynchronously; no stall after release.
